// File: rtl/clint_pkg.sv
// clint_pkg: register map, interrupt bit positions and write-merge helper
// shared by the core-local interruptor.
package clint_pkg;
    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0200_0000;
    localparam logic [15:0] MSIP_OFF     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;
    localparam int MSTATUS_MIE_BIT = 3;
    localparam int MIE_MTIE_BIT    = 7;
    localparam int MIE_MSIE_BIT    = 3;

    function automatic logic [63:0] merge_write(input logic [63:0] old, input logic [63:0] wdata,
                                                input logic [7:0] wmask);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{wmask[i]}};
        return (old & ~m) | (wdata & m);
    endfunction
endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides the core clock into mtime increment ticks.
module clint_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);
    logic [15:0] cnt;

    always_comb tick = cnt == LAST;

    always_ff @(posedge clock) begin
        if (reset) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 16'd1;
    end
endmodule

// File: rtl/clint_timer.sv
// clint_timer: msip/mtimecmp/mtime registers behind a valid/ready port,
// producing MIE/mie-qualified timer and software interrupts.
module clint_timer
    import clint_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    input  logic [63:0] csr_mstatus,
    input  logic [63:0] csr_mie,
    output logic        time_irq,
    output logic        soft_irq,
    output logic [63:0] mtime_o
);
    logic [63:0] mtime, mtimecmp, rd_val, msip_new;
    logic        msip, tick, accept, wr, in_win, hit_msip, hit_cmp, hit_time;
    logic [15:0] off;

    clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (.clock(clock), .reset(reset), .tick(tick));

    always_comb begin
        req_ready = !resp_valid | resp_ready;
        accept    = req_valid & req_ready;
        wr        = accept & req_wen;
        in_win    = req_addr[63:16] == BASE_ADDR[63:16];
        off       = {req_addr[15:3], 3'b000};
        hit_msip  = in_win & (off == MSIP_OFF);
        hit_cmp   = in_win & (off == MTIMECMP_OFF);
        hit_time  = in_win & (off == MTIME_OFF);
        rd_val    = hit_msip ? {63'd0, msip} : hit_cmp ? mtimecmp : hit_time ? mtime : 64'd0;
        msip_new  = merge_write({63'd0, msip}, req_wdata, req_wmask);
        mtime_o   = mtime;
        time_irq  = csr_mstatus[MSTATUS_MIE_BIT] & csr_mie[MIE_MTIE_BIT] & (mtime >= mtimecmp);
        soft_irq  = csr_mstatus[MSTATUS_MIE_BIT] & csr_mie[MIE_MSIE_BIT] & msip;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mtime      <= '0;
            mtimecmp   <= '1;
            msip       <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (wr && hit_msip) msip <= msip_new[0];
            if (wr && hit_cmp) mtimecmp <= merge_write(mtimecmp, req_wdata, req_wmask);
            // a software write to mtime overrides that cycle's increment
            if (wr && hit_time) mtime <= merge_write(mtime, req_wdata, req_wmask);
            else if (tick) mtime <= mtime + 64'd1;
            if (accept) begin
                resp_valid <= 1'b1;
                resp_rdata <= req_wen ? 64'd0 : rd_val;
                resp_err   <= !(hit_msip | hit_cmp | hit_time);
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end
endmodule
